// File: rtl/sum_bcd_display_if.sv
`default_nettype none
// ============================================================================
// Module   : sum_bcd_display_if
// Purpose  : Request/result bundle between the adder datapath and the
//            BCD / 7-segment display converter.
// Revision : 1.0  initial release
// ============================================================================
interface sum_bcd_display_if #(
  parameter int WIDTH  = 9,
  parameter int DIGITS = 3
);
  logic [WIDTH-1:0]    data_in;
  logic                valid_in;
  logic                ready_out;
  logic                busy;
  logic [4*DIGITS-1:0] bcd_out;
  logic [7*DIGITS-1:0] seg_out;
  logic                valid_out;

  // Upstream producer side
  modport master (
    output data_in, valid_in,
    input  ready_out, busy, bcd_out, seg_out, valid_out
  );

  // Converter side
  modport slave (
    input  data_in, valid_in,
    output ready_out, busy, bcd_out, seg_out, valid_out
  );
endinterface
`default_nettype wire

// File: rtl/sum_bcd_display.sv
`default_nettype none
// ============================================================================
// Module   : sum_bcd_display
// Purpose  : Iterative double-dabble conversion of the registered adder
//            result to BCD, with active-low 7-segment decode and optional
//            leading-zero blanking.
// Revision : 1.0  initial release
// ============================================================================
module sum_bcd_display #(
  parameter int WIDTH         = 9,
  parameter int DIGITS        = 3,
  parameter bit BLANK_LEADING = 1'b0
) (
  input  wire logic         clock,
  input  wire logic         reset,
  sum_bcd_display_if.slave  bus
);

  localparam int SR_W  = 4*DIGITS + WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  // Segment pattern {g,f,e,d,c,b,a}, active-low
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Full display word; zeros above the first non-zero digit are blanked
  // when enabled, digit 0 always shows.
  function automatic logic [7*DIGITS-1:0] encode_all(input logic [4*DIGITS-1:0] b);
    logic lead;
    logic [3:0] d;
    encode_all = '0;
    lead = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      d = b[4*i +: 4];
      if (BLANK_LEADING && lead && (d == 4'd0) && (i != 0)) begin
        encode_all[7*i +: 7] = 7'b1111111;
      end else begin
        encode_all[7*i +: 7] = seg7(d);
        lead = 1'b0;
      end
    end
  endfunction

  localparam logic [7*DIGITS-1:0] SEG_RESET = encode_all('0);

  state_t              state, state_next;
  logic [SR_W-1:0]     sr;        // {scratch BCD digits, binary remainder}
  logic [SR_W-1:0]     sr_corr;
  logic [CNT_W-1:0]    cnt;
  logic [4*DIGITS-1:0] bcd_q;
  logic [7*DIGITS-1:0] seg_q;
  logic                valid_q;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.valid_in) state_next = SHIFT;
      SHIFT:   if (cnt == CNT_W'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Add-3 correction of every scratch digit that is 5 or more
  always_comb begin
    sr_corr = sr;
    for (int i = 0; i < DIGITS; i++) begin
      if (sr[WIDTH + 4*i +: 4] >= 4'd5)
        sr_corr[WIDTH + 4*i +: 4] = sr[WIDTH + 4*i +: 4] + 4'd3;
    end
  end

  // Conversion datapath: load on acceptance, correct-then-shift while busy
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sr  <= '0;
      cnt <= '0;
    end else if (state == IDLE && bus.valid_in) begin
      sr  <= {{(4*DIGITS){1'b0}}, bus.data_in};
      cnt <= CNT_W'(WIDTH);
    end else if (state == SHIFT) begin
      sr  <= sr_corr << 1;
      cnt <= cnt - 1'b1;
    end
  end

  // Result registers, updated and flagged only in DONE
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bcd_q   <= '0;
      seg_q   <= SEG_RESET;
      valid_q <= 1'b0;
    end else begin
      valid_q <= (state == DONE);
      if (state == DONE) begin
        bcd_q <= sr[SR_W-1:WIDTH];
        seg_q <= encode_all(sr[SR_W-1:WIDTH]);
      end
    end
  end

  assign bus.ready_out = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.bcd_out   = bcd_q;
  assign bus.seg_out   = seg_q;
  assign bus.valid_out = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_sum_bcd_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_sum_bcd_display
// Purpose  : Directed self-checking bench; one converter without and one
//            with leading-zero blanking, driven with identical stimulus.
// Revision : 1.0  initial release
// ============================================================================
module tb_sum_bcd_display;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S5 = 7'b0010010, S4 = 7'b0011001, S7 = 7'b1111000,
                         SB = 7'b1111111;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  sum_bcd_display_if #(.WIDTH(9), .DIGITS(3)) bus0 ();
  sum_bcd_display_if #(.WIDTH(9), .DIGITS(3)) bus1 ();

  sum_bcd_display #(.WIDTH(9), .DIGITS(3), .BLANK_LEADING(1'b0)) u_dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (bus0)
  );

  sum_bcd_display #(.WIDTH(9), .DIGITS(3), .BLANK_LEADING(1'b1)) u_dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [8:0] d);
    bus0.valid_in = v; bus0.data_in = d;
    bus1.valid_in = v; bus1.data_in = d;
  endtask

  // Accept one value and wait for the result; checks latency and pulse width
  task automatic convert(input string tag, input logic [8:0] d,
                         input logic [11:0] exp_bcd,
                         input logic [20:0] exp_seg0, input logic [20:0] exp_seg1);
    int lat;
    @(negedge clock);
    check({tag, "_ready"}, {31'd0, bus0.ready_out}, 32'd1);
    drive(1'b1, d);
    @(posedge clock);           // E0
    @(negedge clock);
    drive(1'b0, 9'd0);
    lat = 0;
    while (!bus0.valid_out && lat < 30) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
    end
    check({tag, "_latency"}, lat, 32'd10);
    check({tag, "_bcd0"}, {20'd0, bus0.bcd_out}, {20'd0, exp_bcd});
    check({tag, "_seg0"}, {11'd0, bus0.seg_out}, {11'd0, exp_seg0});
    check({tag, "_bcd1"}, {20'd0, bus1.bcd_out}, {20'd0, exp_bcd});
    check({tag, "_seg1"}, {11'd0, bus1.seg_out}, {11'd0, exp_seg1});
    check({tag, "_ready_w_valid"}, {31'd0, bus0.ready_out}, 32'd1);
    @(negedge clock);
    check({tag, "_pulse1"}, {31'd0, bus0.valid_out}, 32'd0);
  endtask

  // Stimulus sequence
  initial begin
    int lows;
    int pulses;
    drive(1'b0, 9'd0);

    // Reset state
    #25;
    check("rst_ready", {31'd0, bus0.ready_out}, 32'd1);
    check("rst_busy",  {31'd0, bus0.busy}, 32'd0);
    check("rst_valid", {31'd0, bus0.valid_out}, 32'd0);
    check("rst_bcd",   {20'd0, bus0.bcd_out}, 32'd0);
    check("rst_seg0",  {11'd0, bus0.seg_out}, {11'd0, S0, S0, S0});
    check("rst_seg1",  {11'd0, bus1.seg_out}, {11'd0, SB, SB, S0});
    @(negedge clock);
    reset = 1'b1;

    convert("zero", 9'd0,   12'h000, {S0, S0, S0}, {SB, SB, S0});
    convert("max",  9'd511, 12'h511, {S5, S1, S1}, {S5, S1, S1});

    // Requests while busy are dropped
    @(negedge clock);
    drive(1'b1, 9'd255);
    @(posedge clock);           // E0
    @(negedge clock);
    drive(1'b1, 9'd7);
    lows   = bus0.ready_out ? 0 : 1;
    pulses = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (!bus0.ready_out) lows++;
      if (bus0.valid_out)  pulses++;
    end
    check("busy_bcd", {20'd0, bus0.bcd_out}, 32'h255);
    check("busy_seg", {11'd0, bus0.seg_out}, {11'd0, S2, S5, S5});
    drive(1'b0, 9'd0);
    for (int i = 0; i < 14; i++) begin
      @(negedge clock);
      if (bus0.valid_out) pulses++;
    end
    check("busy_ready_low", lows, 32'd10);
    check("busy_pulses", pulses, 32'd1);
    check("busy_bcd_hold", {20'd0, bus0.bcd_out}, 32'h255);

    // Reset in the middle of a conversion
    @(negedge clock);
    drive(1'b1, 9'd300);
    @(posedge clock);           // E0
    @(negedge clock);
    drive(1'b0, 9'd0);
    repeat (4) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("abort_ready", {31'd0, bus0.ready_out}, 32'd1);
    check("abort_bcd",   {20'd0, bus0.bcd_out}, 32'd0);
    check("abort_seg0",  {11'd0, bus0.seg_out}, {11'd0, S0, S0, S0});
    check("abort_seg1",  {11'd0, bus1.seg_out}, {11'd0, SB, SB, S0});
    @(negedge clock);
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clock);
      if (bus0.valid_out || bus1.valid_out) pulses++;
    end
    check("abort_no_valid", pulses, 32'd0);
    convert("after_abort", 9'd100, 12'h100, {S1, S0, S0}, {S1, S0, S0});

    // Leading-zero blanking
    convert("blank7",  9'd7,  12'h007, {S0, S0, S7}, {SB, SB, S7});
    convert("blank40", 9'd40, 12'h040, {S0, S4, S0}, {SB, S4, S0});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
